sequenciador_exibicao: RTL
==========================

SEQUENCIADOR_EXIBICAO -- requirements
Module: sequenciador_exibicao

Interface
REQ-001 SHALL have parameter T_ON, default 500, LED-on time per sequence item in clock cycles (legal range >= 1).
REQ-002 SHALL have parameter T_OFF, default 250, LED-off gap after each item in clock cycles (legal range >= 1).
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iniciar  input  1  request to play back the stored sequence; level sampled each cycle.
REQ-006 SHALL have port abortar  input  1  cancel playback in progress.
REQ-007 SHALL have port enderecoIgualLimite  input  1  datapath flag: current memory address equals round limit.
REQ-008 SHALL have port zera_endereco  output  1  one-cycle clear of datapath address counter.
REQ-009 SHALL have port conta_endereco  output  1  one-cycle increment of datapath address counter.
REQ-010 SHALL have port leds_en  output  1  gates memory data onto the LEDs.
REQ-011 SHALL have port ocupado  output  1  playback in progress.
REQ-012 SHALL have port pronto  output  1  one-cycle pulse on normal playback completion.
REQ-013 SHALL have port db_estado  output  4  current state code for the hex debug display.

Function
REQ-014 SHALL be a Moore FSM with states and codes: OCIOSO=0, INICIO=1, ACENDE=2, APAGA=3, PROXIMO=4, FIM=5; codes 6-15 unreachable and SHALL recover to OCIOSO.
REQ-015 OCIOSO: all control outputs 0; iniciar=1 and abortar=0 -> INICIO; otherwise stay.
REQ-016 INICIO: zera_endereco=1 for exactly one cycle, timer cleared -> ACENDE.
REQ-017 ACENDE: leds_en=1; timer counts 0..T_ON-1; on timer=T_ON-1 -> APAGA with timer cleared (exactly T_ON cycles in ACENDE).
REQ-018 APAGA: leds_en=0; timer counts 0..T_OFF-1; on timer=T_OFF-1 -> FIM if enderecoIgualLimite=1, else PROXIMO.
REQ-019 enderecoIgualLimite SHALL be sampled only in the last APAGA cycle.
REQ-020 PROXIMO: conta_endereco=1 for exactly one cycle, timer cleared -> ACENDE (gives memory one cycle of read latency before LEDs light).
REQ-021 FIM: pronto=1 for exactly one cycle -> OCIOSO.
REQ-022 ocupado SHALL be 1 in every state except OCIOSO.
REQ-023 abortar=1 in any state other than OCIOSO SHALL force OCIOSO on the next edge, overriding timer expiry; pronto SHALL NOT pulse.
REQ-024 iniciar while ocupado=1 SHALL be ignored; a held iniciar SHALL restart playback after FIM->OCIOSO (one idle cycle between runs).
REQ-025 Timer width SHALL be clog2(max(T_ON,T_OFF)) bits minimum, with no wrap before terminal count.
REQ-026 Total run for N items (N = limit+1) SHALL be 1 + N*(T_ON+T_OFF) + (N-1) + 1 cycles from INICIO through FIM inclusive.

Reset
REQ-027 reset=0 SHALL immediately force OCIOSO, timer=0, zera_endereco=0, conta_endereco=0, leds_en=0, ocupado=0, pronto=0, db_estado=0, regardless of clock.
REQ-028 Reset assertion mid-playback SHALL leave no residual pulse after release; first post-reset cycle is OCIOSO.

Structure
REQ-029 State codes and db_estado encoding SHALL live in a shared constants package/include used by this block and the debug display logic.
REQ-030 The T_ON/T_OFF timer SHALL be one sub-module, contador_tempo (sync clear, enable, terminal-count flag), instantiated once.

Verification (T_ON=4, T_OFF=2; cycle 0 = first edge with iniciar=1)
REQ-031 Reset: reset=0 mid-ACENDE -> all outputs 0, db_estado=0 at once, without waiting for an edge.
REQ-032 Single item (enderecoIgualLimite=1): zera_endereco at cycle 1, leds_en cycles 2-5, off 6-7, pronto cycle 8, ocupado cycles 1-8.
REQ-033 Three items (flag rises after second conta_endereco): conta_endereco at cycles 8 and 15 only, leds_en 2-5/9-12/16-19, pronto at cycle 22.
REQ-034 Abort: abortar=1 at cycle 10 in a 3-item run -> db_estado=0, leds_en=0 from cycle 11, no pronto, no further conta_endereco.
REQ-035 Busy ignore: iniciar pulsed at cycle 5 of a single-item run -> no new zera_endereco before cycle 8; exactly one pronto.
REQ-036 Simultaneous: iniciar=1 and abortar=1 in OCIOSO -> stays OCIOSO, ocupado=0.

Source files
------------

// File: rtl/sequenciador_exibicao_pkg.sv
// sequenciador_exibicao_pkg
// Shared constants for the LED playback sequencer and the hex debug display:
// state codes (which are also the db_estado encoding) and timer sizing helper.
package sequenciador_exibicao_pkg;

  localparam int unsigned ESTADO_W = 4;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO  = 4'd0,
    INICIO  = 4'd1,
    ACENDE  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  // Debug display shows the raw state code.
  function automatic logic [ESTADO_W-1:0] codigo_db(input estado_t e);
    return e;
  endfunction

  // Bits needed to hold 0..max(a,b)-1, never less than one.
  function automatic int unsigned largura_tempo(input int unsigned a,
                                                input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sequenciador_exibicao_contador_tempo.sv
// contador_tempo
// Up-counter for the LED on/off intervals. Counts from 0 while enabled and
// holds at the terminal value (no wrap); a synchronous clear has priority.
// Ports:
//   clock, reset   - system clock, async active-low reset
//   clear_i        - synchronous clear to 0
//   en_i           - count enable
//   limite_i       - terminal count value (interval length - 1)
//   fim_o          - terminal-count flag (count == limite_i)
module contador_tempo #(
  parameter int unsigned W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         en_i,
  input  logic [W-1:0] limite_i,
  output logic         fim_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign fim_o = (cnt_q == limite_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !fim_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sequenciador_exibicao.sv
// sequenciador_exibicao
// Moore FSM that plays back a stored LED sequence: each item is lit for T_ON
// cycles, then dark for T_OFF cycles; the datapath address is cleared at the
// start and incremented between items until enderecoIgualLimite is seen.
// Ports:
//   clock, reset          - system clock, async active-low reset
//   iniciar               - start request (level, ignored while busy)
//   abortar               - cancel playback, back to idle next edge
//   enderecoIgualLimite   - datapath: address equals round limit
//   zera_endereco         - one-cycle clear of the address counter
//   conta_endereco        - one-cycle increment of the address counter
//   leds_en               - gate memory data onto the LEDs
//   ocupado               - playback in progress
//   pronto                - one-cycle pulse on normal completion
//   db_estado             - state code for the debug display
//
// state   | meaning
// --------+------------------------------------------------------------
// OCIOSO  | idle, waiting for iniciar
// INICIO  | clear datapath address (one cycle)
// ACENDE  | LEDs on for T_ON cycles
// APAGA   | LEDs off for T_OFF cycles, then check limit flag
// PROXIMO | increment address (one cycle of memory read latency)
// FIM     | pulse pronto, back to idle
module sequenciador_exibicao
  import sequenciador_exibicao_pkg::*;
#(
  parameter int unsigned T_ON  = 500,
  parameter int unsigned T_OFF = 250
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                abortar,
  input  logic                enderecoIgualLimite,
  output logic                zera_endereco,
  output logic                conta_endereco,
  output logic                leds_en,
  output logic                ocupado,
  output logic                pronto,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam int unsigned TW = largura_tempo(T_ON, T_OFF);
  localparam logic [TW-1:0] LIM_ON  = TW'(T_ON - 1);
  localparam logic [TW-1:0] LIM_OFF = TW'(T_OFF - 1);

  estado_t       estado_q;
  estado_t       estado_d;
  logic          tempo_fim;
  logic          tempo_clr;
  logic          tempo_en;
  logic [TW-1:0] tempo_lim;

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (iniciar && !abortar) estado_d = INICIO;
      INICIO:  estado_d = ACENDE;
      ACENDE:  if (tempo_fim) estado_d = APAGA;
      APAGA:   if (tempo_fim) estado_d = enderecoIgualLimite ? FIM : PROXIMO;
      PROXIMO: estado_d = ACENDE;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
    if (abortar && (estado_q != OCIOSO)) begin
      estado_d = OCIOSO;
    end
  end

  // Clearing on every state change means each state is entered with the
  // timer at zero, so ACENDE/APAGA each last exactly their interval.
  assign tempo_clr = (estado_d != estado_q);
  assign tempo_en  = (estado_q == ACENDE) || (estado_q == APAGA);
  assign tempo_lim = (estado_q == APAGA) ? LIM_OFF : LIM_ON;

  contador_tempo #(
    .W(TW)
  ) u_tempo (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (tempo_clr),
    .en_i     (tempo_en),
    .limite_i (tempo_lim),
    .fim_o    (tempo_fim)
  );

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q       <= OCIOSO;
      zera_endereco  <= 1'b0;
      conta_endereco <= 1'b0;
      leds_en        <= 1'b0;
      ocupado        <= 1'b0;
      pronto         <= 1'b0;
      db_estado      <= '0;
    end else begin
      estado_q       <= estado_d;
      zera_endereco  <= (estado_d == INICIO);
      conta_endereco <= (estado_d == PROXIMO);
      leds_en        <= (estado_d == ACENDE);
      ocupado        <= (estado_d != OCIOSO);
      pronto         <= (estado_d == FIM);
      db_estado      <= codigo_db(estado_d);
    end
  end

endmodule
